// File: rtl/trace_pkg.sv
// Shared state encoding, record layout and default widths for the
// write-back trace capture block.
package trace_pkg;

  localparam int DEF_PC_W        = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_HALT_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_DATA_W-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy, full/empty and
// a flag for a push that could not be stored.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 64
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_pop;
  logic          w_wr;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_pop  = i_pop && !o_empty;
  assign w_wr   = i_push && (!o_full || w_pop);
  assign o_drop = i_push && o_full && !w_pop;

  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Write-back trace capture: records {PC, WriteData} on each retirement and stops on halt.
// Build macro TRACE_PC_FILTER_EN limits capture to PCs within PC_LO..PC_HI.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | not capturing; waits for cap_en
// ST_CAPTURE | pushes a record whenever the PC changes
// ST_HALTED  | PC stuck; capture stopped until reset, FIFO drains
module wb_trace_capture
  import trace_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              DEPTH       = DEF_DEPTH,
  parameter int              HALT_CYCLES = DEF_HALT_CYCLES,
  parameter logic [PC_W-1:0] PC_LO       = '0,
  parameter logic [PC_W-1:0] PC_HI       = '1
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_W-1:0]        ProgramCounter,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   cap_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   halted
);

  localparam int              RW      = PC_W + DATA_W;
  localparam int              SW      = $clog2(HALT_CYCLES);
  localparam logic [SW-1:0]   HALT_TC = SW'(HALT_CYCLES - 2);

  trace_state_e      r_state;
  trace_state_e      w_state_nxt;
  logic [PC_W-1:0]   r_prev_pc;
  logic              r_first;
  logic [SW-1:0]     r_stall_cnt;
  logic              r_stg_vld;
  logic [RW-1:0]     r_stg_rec;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;
  logic              r_halted;

  logic              w_capturing;
  logic              w_same;
  logic              w_halt_hit;
  logic              w_in_window;
  logic              w_event;
  logic [RW-1:0]     w_head;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_drop;
  logic              w_unused;

  assign w_capturing = (r_state == ST_CAPTURE) && cap_en;
  assign w_same      = (ProgramCounter == r_prev_pc);
  // Stall counter already at HALT_CYCLES-2 and another repeat: it reaches HALT_CYCLES-1 now.
  assign w_halt_hit  = w_capturing && w_same && (r_stall_cnt == HALT_TC);

`ifdef TRACE_PC_FILTER_EN
  assign w_in_window = (ProgramCounter >= PC_LO) && (ProgramCounter <= PC_HI);
`else
  assign w_in_window = 1'b1;
`endif

  assign w_event = w_capturing && !w_halt_hit && (r_first || !w_same) && w_in_window;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (cap_en) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!cap_en)         w_state_nxt = ST_IDLE;
        else if (w_halt_hit) w_state_nxt = ST_HALTED;
      end
      ST_HALTED:  w_state_nxt = ST_HALTED;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // The staging register gives one edge between sampling and the FIFO write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_prev_pc   <= '0;
      r_first     <= 1'b1;
      r_stall_cnt <= '0;
      r_stg_vld   <= 1'b0;
      r_stg_rec   <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev_pc <= ProgramCounter;
      r_stg_vld <= w_event;
      if (w_event) begin
        r_stg_rec <= {ProgramCounter, WriteData};
        r_first   <= 1'b0;
      end
      if (w_capturing && w_same) r_stall_cnt <= r_stall_cnt + 1'b1;
      else                       r_stall_cnt <= '0;
      if (w_halt_hit) r_halted <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_stg_vld),
    .i_din   (r_stg_rec),
    .i_pop   (out_ready),
    .o_dout  (w_head),
    .o_level (level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_drop  (w_drop)
  );

  assign out_valid = !w_fifo_empty;
  assign out_pc    = w_head[RW-1:DATA_W];
  assign out_data  = w_head[DATA_W-1:0];
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign halted    = r_halted;

  // Window bounds only matter in the filtered build; full flag is informational.
  assign w_unused = ^{w_fifo_full, PC_LO, PC_HI};

endmodule

// File: tb/tb_wb_trace_capture.sv
// Self-checking bench for wb_trace_capture: directed scenarios plus a random
// phase compared against a record-level reference model.
`timescale 1ns/1ps
module tb_wb_trace_capture;

  localparam int          PC_W        = 32;
  localparam int          DATA_W      = 32;
  localparam int          DEPTH       = 16;
  localparam int          HALT_CYCLES = 8;
  localparam logic [31:0] WIN_LO      = 32'h10;
  localparam logic [31:0] WIN_HI      = 32'h1C;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [PC_W-1:0]   ProgramCounter = '0;
  logic [DATA_W-1:0] WriteData = '0;
  logic              cap_en = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              halted;

  wb_trace_capture #(
    .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES),
    .PC_LO(WIN_LO), .PC_HI(WIN_HI)
  ) dut (
    .clk(clk), .rst(rst), .ProgramCounter(ProgramCounter), .WriteData(WriteData),
    .cap_en(cap_en), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_data(out_data), .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: expected FIFO contents as a queue of records.
  logic [63:0] m_q[$];
  logic [63:0] got_q[$];
  bit          m_stg_vld;
  logic [63:0] m_stg;
  logic [31:0] m_prev;
  bit          m_first;
  int          m_run;
  int          m_mode;   // 0 idle, 1 capturing, 2 halted
  bit          m_halt;
  bit          m_ovf;
  int          m_drops;

  task automatic model_reset();
    m_q.delete();
    m_stg_vld = 0; m_stg = '0; m_prev = '0; m_first = 1;
    m_run = 0; m_mode = 0; m_halt = 0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_edge();
    bit same, win, capturing;
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (m_stg_vld) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_stg);
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    m_stg_vld = 0;
    same = (ProgramCounter == m_prev);
    win = 1'b1;
`ifdef TRACE_PC_FILTER_EN
    win = (ProgramCounter >= WIN_LO) && (ProgramCounter <= WIN_HI);
`endif
    capturing = (m_mode == 1) && cap_en;
    if (capturing) begin
      m_run = same ? m_run + 1 : 0;
      if (m_run == HALT_CYCLES - 1) begin
        m_halt = 1; m_mode = 2;
      end else if ((m_first || !same) && win) begin
        m_stg_vld = 1; m_stg = {ProgramCounter, WriteData}; m_first = 0;
      end
    end else begin
      m_run = 0;
    end
    if (m_mode == 0 && cap_en) m_mode = 1;
    else if (m_mode == 1 && !cap_en) m_mode = 0;
    m_prev = ProgramCounter;
  endtask

  task automatic step();
    if (out_valid && out_ready) got_q.push_back({out_pc, out_data});
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    #2;
    model_reset();
    got_q.delete();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++;
    if (overflow !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL reset_flags got ovf=%0b halt=%0b exp=0/0", overflow, halted);
    end
    checks++;
    if (drop_cnt !== 16'd0 || out_pc !== '0 || out_data !== '0) begin
      failures++; $display("FAIL reset_data got drop=%0d pc=%0h data=%0h exp=0", drop_cnt, out_pc, out_data);
    end
    checks++;
  endtask

  task automatic test_basic_order();
    logic [63:0] exp_r [4];
    exp_r[0] = {32'h0, 32'h1}; exp_r[1] = {32'h4, 32'h2};
    exp_r[2] = {32'h8, 32'h3}; exp_r[3] = {32'hC, 32'h4};
    do_reset();
    cap_en = 1; out_ready = 1;
    step();
    ProgramCounter = 32'h0; WriteData = 32'h1; step();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%0b exp=0", out_valid); end
    checks++;
    ProgramCounter = 32'h4; WriteData = 32'h2; step();
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL latency_valid got v=%0b pc=%0h exp v=1 pc=0", out_valid, out_pc);
    end
    checks++;
    ProgramCounter = 32'h8; WriteData = 32'h3; step();
    ProgramCounter = 32'hC; WriteData = 32'h4; step();
    for (int i = 0; i < 4; i++) step();
    if (got_q.size() !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    checks++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_r[i]) begin failures++; $display("FAIL basic_rec%0d got=%h exp=%h", i, got_q[i], exp_r[i]); end
      checks++;
    end
    if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", overflow); end
    checks++;
  endtask

  task automatic test_overflow();
    logic [63:0] recs [20];
    logic [31:0] base;
    logic [63:0] head;
    base = $urandom & 32'hFFFF_0000;
    do_reset();
    cap_en = 1; step();
    for (int i = 0; i < 20; i++) begin
      ProgramCounter = base + 32'(4 * i); WriteData = $urandom;
      recs[i] = {ProgramCounter, WriteData};
      step();
    end
    step();
    if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      failures++; $display("FAIL ovf_state got lvl=%0d ovf=%0b drop=%0d exp 16/1/4", level, overflow, drop_cnt);
    end
    checks++;
    cap_en = 0;
    head = {out_pc, out_data};
    step(); step();
    if ({out_pc, out_data} !== head || head !== recs[0]) begin
      failures++; $display("FAIL ovf_hold got=%h exp=%h", {out_pc, out_data}, recs[0]);
    end
    checks++;
    out_ready = 1;
    for (int i = 0; i < 18; i++) step();
    if (got_q.size() !== 16) begin failures++; $display("FAIL ovf_drain_cnt got=%0d exp=16", got_q.size()); end
    checks++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      if (got_q[i] !== recs[i]) begin failures++; $display("FAIL ovf_rec%0d got=%h exp=%h", i, got_q[i], recs[i]); end
      checks++;
    end
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_empty got lvl=%0d v=%0b exp 0/0", level, out_valid);
    end
    checks++;
  endtask

  task automatic test_full_pop_random();
    logic [63:0] recs [17];
    logic [31:0] base;
    base = $urandom & 32'hFFFF_0000;
    do_reset();
    cap_en = 1; step();
    for (int i = 0; i < 16; i++) begin
      ProgramCounter = base + 32'(4 * i); WriteData = $urandom;
      recs[i] = {ProgramCounter, WriteData};
      step();
    end
    step();
    ProgramCounter = base + 32'h40; WriteData = $urandom;
    recs[16] = {ProgramCounter, WriteData};
    step();
    out_ready = 1; step(); out_ready = 0;
    if (level !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL fullpop_state got lvl=%0d drop=%0d ovf=%0b exp 16/0/0", level, drop_cnt, overflow);
    end
    checks++;
    if ({out_pc, out_data} !== recs[1]) begin
      failures++; $display("FAIL fullpop_head got=%h exp=%h", {out_pc, out_data}, recs[1]);
    end
    checks++;
    for (int i = 0; i < 120; i++) begin
      cap_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) ProgramCounter = $urandom_range(0, 31) * 4;
      WriteData = $urandom;
      out_ready = $urandom_range(0, 1);
      step();
      if (level !== 5'(m_q.size()) || out_valid !== (m_q.size() != 0)) begin
        failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, m_q.size());
      end
      checks++;
      if (m_q.size() != 0 && {out_pc, out_data} !== m_q[0]) begin
        failures++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", i, {out_pc, out_data}, m_q[0]);
      end
      checks++;
      if (overflow !== m_ovf || drop_cnt !== 16'(m_drops) || halted !== m_halt) begin
        failures++; $display("FAIL rand_flags cyc=%0d got ovf=%0b drop=%0d halt=%0b exp %0b/%0d/%0b",
                             i, overflow, drop_cnt, halted, m_ovf, m_drops, m_halt);
      end
      checks++;
    end
  endtask

  task automatic test_halt();
    logic [63:0] exp_r [3];
    do_reset();
    cap_en = 1; step();
    ProgramCounter = 32'h10; WriteData = $urandom; exp_r[0] = {ProgramCounter, WriteData}; step();
    ProgramCounter = 32'h14; WriteData = $urandom; exp_r[1] = {ProgramCounter, WriteData}; step();
    ProgramCounter = 32'h20; WriteData = $urandom; exp_r[2] = {ProgramCounter, WriteData};
    for (int i = 1; i <= 8; i++) begin
      step();
      WriteData = $urandom;
      if (i == 7) begin
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%0b exp=0", halted); end
        checks++;
      end
    end
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%0b exp=1", halted); end
    checks++;
    ProgramCounter = 32'h24;
    for (int i = 0; i < 3; i++) step();
    if (level !== 5'd3) begin failures++; $display("FAIL halt_nocap got=%0d exp=3", level); end
    checks++;
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    if (got_q.size() !== 3) begin failures++; $display("FAIL halt_drain_cnt got=%0d exp=3", got_q.size()); end
    checks++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_r[i]) begin failures++; $display("FAIL halt_rec%0d got=%h exp=%h", i, got_q[i], exp_r[i]); end
      checks++;
    end
    if (halted !== 1'b1 || level !== 5'd0) begin
      failures++; $display("FAIL halt_sticky got halt=%0b lvl=%0d exp 1/0", halted, level);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    int budget;
    do_reset();
    cap_en = 1; step();
    for (int i = 0; i < 5; i++) begin
      ProgramCounter = 32'h100 + 32'(8 * i); WriteData = $urandom; step();
    end
    budget = 0;
    while (halted !== 1'b1 && budget < 20) begin step(); budget++; end
    if (halted !== 1'b1 || level !== 5'd5) begin
      failures++; $display("FAIL areset_pre got halt=%0b lvl=%0d exp 1/5", halted, level);
    end
    checks++;
    #2 rst = 1'b0;
    #1;
    if (out_valid !== 1'b0 || level !== 5'd0 || halted !== 1'b0) begin
      failures++; $display("FAIL areset_now got v=%0b lvl=%0d halt=%0b exp 0/0/0", out_valid, level, halted);
    end
    checks++;
    do_reset();
  endtask

`ifdef TRACE_PC_FILTER_EN
  task automatic test_filter();
    do_reset();
    cap_en = 1; out_ready = 1; step();
    for (int i = 0; i < 8; i++) begin
      ProgramCounter = 32'h08 + 32'(4 * i); WriteData = 32'(i); step();
    end
    for (int i = 0; i < 3; i++) step();
    if (got_q.size() !== 4) begin failures++; $display("FAIL filt_count got=%0d exp=4", got_q.size()); end
    checks++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      if (got_q[i][63:32] !== 32'h10 + 32'(4 * i)) begin
        failures++; $display("FAIL filt_pc%0d got=%0h exp=%0h", i, got_q[i][63:32], 32'h10 + 32'(4 * i));
      end
      checks++;
    end
  endtask
`endif

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_basic_order();
    test_overflow();
    test_full_pop_random();
    test_halt();
    test_async_reset();
`ifdef TRACE_PC_FILTER_EN
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
